fifo_flagged: RTL and testbench

//  Next-generation synchronous valid/ready FIFO for the LCD and stream paths.
//  - Supports any DEPTH, not only powers of two.
//  - Optional registered read port.
//  - Occupancy output, programmable almost-full/almost-empty flags, synchronous flush.
//  - Sits between producers (command/pixel generators) and consumers (LCD serializers).

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_flagged_ram.sv | 27 ++
 rtl/fifo_flagged.sv | 115 +++++++++++
 tb/tb_fifo_flagged.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the flagged FIFO: width sizing, pointer wrap and parameter legality.
package fifo_pkg;

    function automatic int unsigned width_of(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic bit params_legal(input int unsigned depth, input int unsigned reg_out,
                                        input int unsigned af, input int unsigned ae);
        int unsigned cap;
        cap = depth + reg_out;
        return (depth >= 32'd2) && (reg_out <= 32'd1) &&
               (af >= 32'd1) && (af <= cap) && (ae <= cap - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_flagged_ram.sv
// Storage array: synchronous write, asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned AW         = width_of(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flagged.sv
// Valid/ready FIFO with arbitrary depth, optional output register, occupancy and
// almost-full/almost-empty flags, and synchronous flush.
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter  int unsigned DEPTH      = 8,
    parameter  int unsigned WORD_WIDTH = 8,
    parameter  int unsigned AF_THRESH  = 6,
    parameter  int unsigned AE_THRESH  = 1,
    parameter  int unsigned REG_OUT    = 0,
    localparam int unsigned CAP        = DEPTH + REG_OUT,
    localparam int unsigned LW         = width_of(CAP + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [LW-1:0]         level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int unsigned PW = width_of(DEPTH);

    if (!params_legal(DEPTH, REG_OUT, AF_THRESH, AE_THRESH)) begin : g_param_err
        $error("fifo_flagged: illegal DEPTH/REG_OUT/threshold parameters");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_adv;
    logic [WORD_WIDTH-1:0] mem_rdata;

    // No pass-through when full: wr_ready depends only on registered level.
    assign wr_ready     = (level_q < LW'(CAP)) && !flush;
    assign wr_fire      = wr_valid && wr_ready;
    assign rd_fire      = rd_valid && rd_ready;
    assign level        = level_q;
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));

    fifo_ram #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_WIDTH),
        .AW         (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (rd_adv) begin
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            unique case ({wr_fire, rd_fire})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    if (REG_OUT != 0) begin : g_oreg
        logic                  ov;
        logic [WORD_WIDTH-1:0] oreg;
        logic                  load;

        // Memory holds level-ov words; refill the head register when it is free or leaving.
        assign load     = (level_q != LW'(ov)) && (!ov || rd_fire);
        assign rd_adv   = load;
        assign rd_valid = ov && !flush;
        assign rd_data  = oreg;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                ov <= 1'b0;
            end else if (load) begin
                ov <= 1'b1;
            end else if (rd_fire) begin
                ov <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (load) begin
                oreg <= mem_rdata;
            end
        end
    end else begin : g_comb
        assign rd_adv   = rd_fire;
        assign rd_valid = (level_q != '0) && !flush;
        assign rd_data  = mem_rdata;
    end

endmodule

// File: tb/tb_fifo_flagged.sv
// Scoreboard bench: REG_OUT=0 and REG_OUT=1 instances driven by shared stimulus.
module tb_fifo_flagged;

    localparam int unsigned DEPTH = 6;
    localparam int unsigned WW    = 8;
    localparam int unsigned AF    = 5;
    localparam int unsigned AE    = 1;
    localparam int          CAP0  = 6;
    localparam int          CAP1  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic [WW-1:0] wr_data = '0;

    logic          wr_ready0, rd_valid0, af0, ae0;
    logic [WW-1:0] rd_data0;
    logic [2:0]    level0;
    logic          wr_ready1, rd_valid1, af1, ae1;
    logic [WW-1:0] rd_data1;
    logic [2:0]    level1;

    always #5 clk = ~clk;

    fifo_flagged #(.DEPTH(DEPTH), .WORD_WIDTH(WW), .AF_THRESH(AF), .AE_THRESH(AE), .REG_OUT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_data(wr_data),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0),
        .level(level0), .almost_full(af0), .almost_empty(ae0)
    );

    fifo_flagged #(.DEPTH(DEPTH), .WORD_WIDTH(WW), .AF_THRESH(AF), .AE_THRESH(AE), .REG_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
        .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_data(rd_data1),
        .level(level1), .almost_full(af1), .almost_empty(ae1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] q0[$];
    logic [WW-1:0] q1[$];
    bit            ov1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle model: check outputs against scoreboard state, then apply this cycle's transfers.
    always @(negedge clk) begin
        int  sz0, sz1, mem1;
        bit  ewr0, erv0, ewr1, erv1, load1;
        if (rst) begin
            q0.delete();
            q1.delete();
            ov1 = 1'b0;
        end else begin
            sz0  = q0.size();
            sz1  = q1.size();
            ewr0 = (sz0 < CAP0) && !flush;
            erv0 = (sz0 > 0) && !flush;
            ewr1 = (sz1 < CAP1) && !flush;
            erv1 = ov1 && !flush;

            check("wr_ready0", 32'(wr_ready0), 32'(ewr0));
            check("rd_valid0", 32'(rd_valid0), 32'(erv0));
            check("level0",    32'(level0),    32'(sz0));
            check("af0",       32'(af0),       32'(sz0 >= int'(AF)));
            check("ae0",       32'(ae0),       32'(sz0 <= int'(AE)));
            check("wr_ready1", 32'(wr_ready1), 32'(ewr1));
            check("rd_valid1", 32'(rd_valid1), 32'(erv1));
            check("level1",    32'(level1),    32'(sz1));
            check("af1",       32'(af1),       32'(sz1 >= int'(AF)));
            check("ae1",       32'(ae1),       32'(sz1 <= int'(AE)));

            if (erv0 && rd_ready) check("rd_data0", 32'(rd_data0), 32'(q0[0]));
            if (erv1 && rd_ready) check("rd_data1", 32'(rd_data1), 32'(q1[0]));

            if (flush) begin
                q0.delete();
                q1.delete();
                ov1 = 1'b0;
            end else begin
                mem1  = sz1 - int'(ov1);
                load1 = (mem1 > 0) && (!ov1 || (erv1 && rd_ready));
                if (load1)                  ov1 = 1'b1;
                else if (erv1 && rd_ready)  ov1 = 1'b0;
                if (erv0 && rd_ready) void'(q0.pop_front());
                if (ewr0 && wr_valid) q0.push_back(wr_data);
                if (erv1 && rd_ready) void'(q1.pop_front());
                if (ewr1 && wr_valid) q1.push_back(wr_data);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_wr_ready0", 32'(wr_ready0), 32'd1);
        check("rst_rd_valid0", 32'(rd_valid0), 32'd0);
        check("rst_level0",    32'(level0),    32'd0);
        check("rst_ae0",       32'(ae0),       32'd1);
        check("rst_af0",       32'(af0),       32'd0);
        check("rst_rd_valid1", 32'(rd_valid1), 32'd0);
        check("rst_level1",    32'(level1),    32'd0);

        // Fill with 0x10..0x16; REG_OUT=0 takes six, REG_OUT=1 takes seven.
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            cyc();
            check("fill_af0", 32'(af0), 32'(i + 1 >= 5));
        end
        check("full_wr_ready0", 32'(wr_ready0), 32'd0);
        check("full_level0",    32'(level0),    32'd6);
        check("full_wr_ready1", 32'(wr_ready1), 32'd0);
        check("full_level1",    32'(level1),    32'd7);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (9) cyc();
        rd_ready = 1'b0;
        check("drain_level0", 32'(level0), 32'd0);
        check("drain_level1", 32'(level1), 32'd0);

        // Steady write+read at level 3 long enough to wrap the pointers several times.
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'h20 + i);
            cyc();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = 8'(8'h30 + i);
            cyc();
            check("wrap_level0", 32'(level0), 32'd3);
            check("wrap_level1", 32'(level1), 32'd3);
        end
        wr_valid = 1'b0;
        repeat (6) cyc();
        rd_ready = 1'b0;

        // Output register latency and extra capacity.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        cyc();
        wr_valid = 1'b0;
        #1;
        check("lat_rd_valid0", 32'(rd_valid0), 32'd1);
        check("lat_rd_valid1", 32'(rd_valid1), 32'd0);
        cyc();
        check("lat_rd_valid1_n1", 32'(rd_valid1), 32'd1);
        check("lat_rd_data1",     32'(rd_data1),  32'hA5);
        rd_ready = 1'b1;
        repeat (2) cyc();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'(8'h40 + i);
            cyc();
        end
        wr_valid = 1'b0;
        #1;
        check("cap_level1",    32'(level1),    32'd7);
        check("cap_wr_ready1", 32'(wr_ready1), 32'd0);
        rd_ready = 1'b1;
        repeat (10) cyc();
        rd_ready = 1'b0;

        // Flush at level 4 with both handshakes requested.
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'h50 + i);
            cyc();
        end
        check("pre_flush_level0", 32'(level0), 32'd4);
        check("pre_flush_level1", 32'(level1), 32'd4);
        flush    = 1'b1;
        wr_data  = 8'h77;
        rd_ready = 1'b1;
        #1;
        check("flush_wr_ready0", 32'(wr_ready0), 32'd0);
        check("flush_rd_valid1", 32'(rd_valid1), 32'd0);
        cyc();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        check("post_flush_level0",    32'(level0),    32'd0);
        check("post_flush_rd_valid0", 32'(rd_valid0), 32'd0);
        check("post_flush_level1",    32'(level1),    32'd0);
        check("post_flush_rd_valid1", 32'(rd_valid1), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        cyc();
        wr_data  = 8'h3D;
        cyc();
        wr_valid = 1'b0;
        #1;
        check("post_flush_head0", 32'(rd_data0), 32'h3C);
        check("post_flush_head1", 32'(rd_data1), 32'h3C);
        rd_ready = 1'b1;
        repeat (4) cyc();
        rd_ready = 1'b0;

        // Random traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            wr_valid = 1'($urandom);
            rd_ready = 1'($urandom);
            wr_data  = 8'($urandom);
            flush    = ($urandom_range(0, 63) == 0);
            cyc();
        end
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (10) cyc();
        rd_ready = 1'b0;
        #1;
        check("end_level0", 32'(level0), 32'd0);
        check("end_level1", 32'(level1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
